// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, assembles
// 11-bit frames and queues good bytes in a FIFO behind a small register map.
//   state    | meaning
//   S_IDLE   | waiting for a start bit (data 0 on a clock strobe)
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | capturing the odd-parity bit
//   S_STOP   | checking stop bit and parity, then pushing or flagging
module ps2_kbd_fifo #(
    parameter int DEPTH   = 16,
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       re,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] data_write,
    output logic [7:0] data_read,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic       irq
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic clk_s1, clk_s2, dat_s1, dat_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2Clk;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2Data;
            dat_s2 <= dat_s1;
        end
    end

    // Down-counter reloads whenever the input agrees with the filtered level
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          strobe;

    assign strobe = clk_filt && !clk_s2 && (filt_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= FW'(FILTER - 1);
        end else if (clk_s2 == clk_filt) begin
            filt_cnt <= FW'(FILTER - 1);
        end else if (filt_cnt == '0) begin
            clk_filt <= clk_s2;
            filt_cnt <= FW'(FILTER - 1);
        end else begin
            filt_cnt <= filt_cnt - 1'b1;
        end
    end

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo;
    logic          push;
    logic [7:0]    push_byte;
    logic          perr_set, ferr_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            par_bit   <= 1'b0;
            tmo       <= '0;
            push      <= 1'b0;
            push_byte <= 8'h00;
            perr_set  <= 1'b0;
            ferr_set  <= 1'b0;
        end else begin
            push     <= 1'b0;
            perr_set <= 1'b0;
            ferr_set <= 1'b0;
            if (strobe) begin
                tmo <= TW'(TIMEOUT - 1);
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (!dat_s2) begin
                            ferr_set <= 1'b1;
                        end else if (^{shreg, par_bit}) begin
                            push      <= 1'b1;
                            push_byte <= shreg;
                        end else begin
                            perr_set <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                // A stalled frame is dropped silently
                if (tmo == '0) state <= S_IDLE;
                else           tmo   <= tmo - 1'b1;
            end
        end
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ovf, perr, ferr;
    logic          full, empty, pop, push_ok, ovf_set, flush, clr;
    logic [7:0]    status;
    logic          unused_bits;

    assign full        = (count == (AW + 1)'(DEPTH));
    assign empty       = (count == '0);
    assign pop         = re && (addr == 8'h00) && !empty;
    assign push_ok     = push && (!full || pop);
    assign ovf_set     = push && full && !pop;
    assign flush       = we && (addr == 8'h03) && data_write[0];
    assign clr         = we && (addr == 8'h03) && data_write[1];
    assign status      = {3'b000, ferr, perr, ovf, full, !empty};
    assign unused_bits = ^data_write[7:2];

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            irq       <= 1'b0;
            data_read <= 8'h00;
        end else begin
            // Flush beats any push or pop in the same cycle
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                case ({push_ok, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
            ovf  <= (ovf  && !clr) || ovf_set;
            perr <= (perr && !clr) || perr_set;
            ferr <= (ferr && !clr) || ferr_set;
            irq  <= !empty;
            if (re) begin
                case (addr)
                    8'h00:   data_read <= empty ? 8'h00 : mem[rd_ptr];
                    8'h01:   data_read <= status;
                    8'h02:   data_read <= 8'(count);
                    default: data_read <= 8'h00;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Bench for ps2_kbd_fifo: drives PS/2 frames, keeps a queue of expected bytes
// and flags, and compares register reads against it.
module tb_ps2_kbd_fifo;
    localparam int DEPTH   = 16;
    localparam int FILTER  = 8;
    localparam int TIMEOUT = 600;
    localparam int HALF    = 40;
    localparam int GAP     = 100;

    logic       clk, reset, re, we;
    logic [7:0] addr, data_write, data_read;
    logic       PS2Clk, PS2Data, irq;

    int   errs   = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];
    bit   e_ovf, e_perr, e_ferr;
    logic [7:0] v;

    ps2_kbd_fifo #(.DEPTH(DEPTH), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr),
        .data_write(data_write), .data_read(data_read),
        .PS2Clk(PS2Clk), .PS2Data(PS2Data), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {3'b000, e_ferr, e_perr, e_ovf, (exp_q.size() == DEPTH), (exp_q.size() != 0)};
    endfunction

    task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        re = 1'b1;
        addr = a;
        @(negedge clk);
        re = 1'b0;
        d = data_read;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b1;
        addr = a;
        data_write = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_fifo(input string tag);
        logic [7:0] d, e;
        bus_rd(8'h00, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        chk(tag, d, e);
    endtask

    task automatic chk_regs(input string tag);
        logic [7:0] d;
        bus_rd(8'h01, d);
        chk({tag, ".status"}, d, exp_status());
        bus_rd(8'h02, d);
        chk({tag, ".count"}, d, 8'(exp_q.size()));
    endtask

    task automatic clear_flags();
        bus_wr(8'h03, 8'h02);
        e_ovf = 0;
        e_perr = 0;
        e_ferr = 0;
    endtask

    // Sends the first nbits of a frame; rd_at_stop lines a DATA read up with
    // the cycle the completed byte is pushed.
    task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par,
                              input bit bad_stop, input bit glitch, input bit rd_at_stop);
        logic [10:0] fr;
        logic [7:0]  d, e;
        int          w;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2Data = fr[i];
            if (glitch && (i == 3 || i == 5)) begin
                w = (i == 3) ? 1 : FILTER - 1;
                repeat (15) @(negedge clk);
                PS2Clk = 1'b0;
                repeat (w) @(negedge clk);
                PS2Clk = 1'b1;
                repeat (HALF - 15 - w) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            PS2Clk = 1'b0;
            if (rd_at_stop && i == 10) begin
                repeat (10) @(negedge clk);
                re = 1'b1;
                addr = 8'h00;
                @(negedge clk);
                re = 1'b0;
                d = data_read;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                chk("read_at_push", d, e);
                repeat (HALF - 11) @(negedge clk);
            end else if (glitch && i == 7) begin
                repeat (15) @(negedge clk);
                PS2Clk = 1'b1;
                repeat (FILTER - 1) @(negedge clk);
                PS2Clk = 1'b0;
                repeat (HALF - 15 - (FILTER - 1)) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            PS2Clk = 1'b1;
        end
        PS2Data = 1'b1;
        repeat (GAP) @(negedge clk);
        if (nbits == 11) begin
            if (bad_stop)                   e_ferr = 1;
            else if (bad_par)               e_perr = 1;
            else if (exp_q.size() < DEPTH)  exp_q.push_back(b);
            else                            e_ovf = 1;
        end
    endtask

    initial begin
        reset = 1'b1;
        re = 1'b0;
        we = 1'b0;
        addr = 8'h00;
        data_write = 8'h00;
        PS2Clk = 1'b1;
        PS2Data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_data_read", data_read, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk_regs("rst");
        rd_fifo("empty_read");
        chk_regs("empty_read_nopop");

        send_frame(8'h1C, 11, 0, 0, 0, 0);
        chk("irq_set", {7'b0, irq}, 8'h01);
        chk_regs("f1c");
        rd_fifo("rd_1c");
        repeat (3) @(negedge clk);
        chk("hold_1c", data_read, 8'h1C);
        chk("irq_clr", {7'b0, irq}, 8'h00);
        chk_regs("f1c_popped");

        send_frame(8'h5A, 11, 1, 0, 0, 0);
        chk_regs("perr");
        clear_flags();
        chk_regs("perr_clr");

        send_frame(8'h33, 11, 0, 1, 0, 0);
        chk_regs("ferr");
        clear_flags();

        for (int b = 0; b <= 16; b++) send_frame(8'(b), 11, 0, 0, 0, 0);
        chk_regs("full");
        chk("irq_full", {7'b0, irq}, 8'h01);
        for (int k = 0; k < DEPTH; k++) rd_fifo("drain");
        chk_regs("drained");
        clear_flags();

        send_frame(8'hF0, 11, 0, 0, 1, 0);
        chk_regs("glitch");
        rd_fifo("rd_f0");

        send_frame(8'hA5, 5, 0, 0, 0, 0);
        repeat (800) @(negedge clk);
        send_frame(8'h29, 11, 0, 0, 0, 0);
        chk_regs("timeout");
        rd_fifo("rd_29");

        for (int b = 8'h40; b <= 8'h4F; b++) send_frame(8'(b), 11, 0, 0, 0, 0);
        send_frame(8'h77, 11, 0, 0, 0, 1);
        chk_regs("full_pushpop");
        rd_fifo("head_adv");
        bus_wr(8'h03, 8'h01);
        exp_q.delete();
        chk_regs("flush");

        send_frame(8'h55, 11, 0, 0, 0, 0);
        bus_wr(8'h04, 8'h03);
        bus_rd(8'h05, v);
        chk("unmapped_rd", v, 8'h00);
        bus_rd(8'h03, v);
        chk("ctrl_rd", v, 8'h00);
        chk_regs("unmapped_wr");
        rd_fifo("rd_55");

        send_frame(8'h99, 6, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        e_ovf = 0;
        e_perr = 0;
        e_ferr = 0;
        send_frame(8'h12, 11, 0, 0, 0, 0);
        chk_regs("mid_reset");
        rd_fifo("rd_12");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
